// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and constants for the two-port APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Width of a counter that must reach timeout-1.
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, on contention the
// port that was not granted last wins.
module apb_rr_pick
    import apb_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] winner_o,
    output logic       valid_o
);

    // Combinational winner selection.
    always_comb begin
        valid_o  = |req_i;
        winner_o = req_i;
        if (req_i == 2'b11) begin
            winner_o = (last_grant_i == PORT_CPU) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master between a CPU port and a DMA port, one transfer
// at a time, with a per-transfer completion timeout.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [1:0]          req,
    input  logic [1:0]          rw,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    input  logic [DATA_W/8-1:0] strb0,
    input  logic [DATA_W/8-1:0] strb1,
    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                Trans,
    output logic                ReadOrWrite,
    output logic [ADDR_W-1:0]   Write_Address,
    output logic [ADDR_W-1:0]   Read_Address,
    output logic [DATA_W-1:0]   INPUT_DATA,
    output logic [DATA_W/8-1:0] Input_STRB,
    input  logic [DATA_W-1:0]   OUT_DATA,
    input  logic                PSLVERR,
    input  logic                xfer_done
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CW     = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic                last_grant_q;
    logic [1:0]          gnt_q;
    logic [1:0]          done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                trans_q;
    logic                rw_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [ADDR_W-1:0]   raddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;

    logic [1:0]          pick_winner;
    logic                pick_valid;
    logic                sel_rw;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_strb;

    apb_rr_pick u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .winner_o     (pick_winner),
        .valid_o      (pick_valid)
    );

    // Command fields of the port the picker selected.
    always_comb begin
        sel_rw    = rw[0];
        sel_addr  = addr0;
        sel_wdata = wdata0;
        sel_strb  = strb0;
        if (pick_winner[1]) begin
            sel_rw    = rw[1];
            sel_addr  = addr1;
            sel_wdata = wdata1;
            sel_strb  = strb1;
        end
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_DMA;
            gnt_q        <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            trans_q      <= 1'b0;
            rw_q         <= 1'b0;
            waddr_q      <= '0;
            raddr_q      <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= pick_winner;
                        trans_q <= 1'b1;
                        rw_q    <= sel_rw;
                        // Only the address/data path for the chosen direction is live.
                        waddr_q <= sel_rw ? '0 : sel_addr;
                        raddr_q <= sel_rw ? sel_addr : '0;
                        wdata_q <= sel_rw ? '0 : sel_wdata;
                        strb_q  <= sel_rw ? '0 : sel_strb;
                        cnt_q   <= '0;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Completion wins over timeout when both land on the same edge.
                    if (xfer_done || (cnt_q == CNT_LAST)) begin
                        done_q  <= gnt_q;
                        trans_q <= 1'b0;
                        rw_q    <= 1'b0;
                        waddr_q <= '0;
                        raddr_q <= '0;
                        wdata_q <= '0;
                        strb_q  <= '0;
                        state_q <= RESP;
                        if (xfer_done) begin
                            rdata_q <= rw_q ? OUT_DATA : '0;
                            err_q   <= PSLVERR;
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    last_grant_q <= gnt_q[1] ? PORT_DMA : PORT_CPU;
                    gnt_q        <= '0;
                    done_q       <= '0;
                    rdata_q      <= '0;
                    err_q        <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign Trans         = trans_q;
    assign ReadOrWrite   = rw_q;
    assign Write_Address = waddr_q;
    assign Read_Address  = raddr_q;
    assign INPUT_DATA    = wdata_q;
    assign Input_STRB    = strb_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios followed by random
// transactions, checked against a transaction-level expectation.
module tb_apb_req_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  req;
    logic [1:0]  rw;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  strb0, strb1;
    logic [1:0]  gnt, done;
    logic [31:0] rdata;
    logic        err, Trans, ReadOrWrite;
    logic [31:0] Write_Address, Read_Address, INPUT_DATA;
    logic [3:0]  Input_STRB;
    logic [31:0] OUT_DATA;
    logic        PSLVERR, xfer_done;

    int n_tests = 0;
    int n_fail  = 0;
    int last_w  = 1;

    apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .rw(rw),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .strb0(strb0), .strb1(strb1), .gnt(gnt), .done(done),
        .rdata(rdata), .err(err), .Trans(Trans), .ReadOrWrite(ReadOrWrite),
        .Write_Address(Write_Address), .Read_Address(Read_Address),
        .INPUT_DATA(INPUT_DATA), .Input_STRB(Input_STRB),
        .OUT_DATA(OUT_DATA), .PSLVERR(PSLVERR), .xfer_done(xfer_done)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction. lat = number of Trans-high cycles before
    // xfer_done is seen; outside 1..TIMEOUT means it never arrives.
    task automatic do_txn(input logic [1:0] rq, input int lat,
                          input logic slverr, input logic [31:0] od);
        int          w;
        int          eff;
        bit          tmo;
        logic        e_rw;
        logic [1:0]  e_g;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_st;
        logic        e_err;

        w      = (rq == 2'b11) ? (1 - last_w) : (rq[1] ? 1 : 0);
        e_g    = (w == 1) ? 2'b10 : 2'b01;
        e_rw   = rw[w];
        e_addr = (w == 1) ? addr1 : addr0;
        e_wd   = (w == 1) ? wdata1 : wdata0;
        e_st   = (w == 1) ? strb1 : strb0;
        tmo    = (lat < 1) || (lat > TIMEOUT);
        eff    = tmo ? TIMEOUT : lat;
        e_rd   = (!tmo && e_rw) ? od : 32'd0;
        e_err  = tmo ? 1'b1 : slverr;

        req = rq;
        tick();
        chk("grant", 64'(gnt), 64'(e_g));

        // Command is latched: scramble the inputs and drop the winner's req.
        req[w] = 1'b0;
        addr0  = $urandom;  addr1  = $urandom;
        wdata0 = $urandom;  wdata1 = $urandom;
        strb0  = 4'($urandom); strb1 = 4'($urandom);

        for (int i = 1; i <= eff; i++) begin
            chk("trans_hi", 64'(Trans), 64'(1'b1));
            chk("rw_out", 64'(ReadOrWrite), 64'(e_rw));
            chk("waddr", 64'(Write_Address), 64'(e_rw ? 32'd0 : e_addr));
            chk("raddr", 64'(Read_Address), 64'(e_rw ? e_addr : 32'd0));
            chk("wdata", 64'(INPUT_DATA), 64'(e_rw ? 32'd0 : e_wd));
            chk("strb", 64'(Input_STRB), 64'(e_rw ? 4'd0 : e_st));
            chk("no_early_done", 64'(done), 64'(2'b00));
            if (!tmo && i == lat) begin
                xfer_done = 1'b1;
                OUT_DATA  = od;
                PSLVERR   = slverr;
            end else begin
                OUT_DATA  = $urandom;
                PSLVERR   = 1'($urandom);
            end
            tick();
            xfer_done = 1'b0;
        end

        chk("done", 64'(done), 64'(e_g));
        chk("trans_lo", 64'(Trans), 64'(1'b0));
        chk("rdata", 64'(rdata), 64'(e_rd));
        chk("err", 64'(err), 64'(e_err));
        chk("gnt_resp", 64'(gnt), 64'(e_g));

        xfer_done = 1'b1;   // outside XFER, must be ignored
        OUT_DATA  = $urandom;
        tick();
        xfer_done = 1'b0;
        chk("done_clr", 64'(done), 64'(2'b00));
        chk("gnt_clr", 64'(gnt), 64'(2'b00));
        chk("rdata_clr", 64'(rdata), 64'(32'd0));
        chk("err_clr", 64'(err), 64'(1'b0));
        last_w = w;
        req    = 2'b00;
    endtask

    initial begin
        logic [1:0]  rq;
        int          lat;
        logic        se;
        logic [31:0] od;

        PRESET = 1'b1; req = 2'b00; rw = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; strb0 = '0; strb1 = '0;
        OUT_DATA = '0; PSLVERR = 1'b0; xfer_done = 1'b0;
        tick();
        tick();
        PRESET = 1'b0;
        chk("rst_gnt", 64'(gnt), 64'(2'b00));
        chk("rst_done", 64'(done), 64'(2'b00));
        chk("rst_trans", 64'(Trans), 64'(1'b0));
        chk("rst_rdata", 64'(rdata), 64'(32'd0));
        chk("rst_err", 64'(err), 64'(1'b0));
        chk("rst_waddr", 64'(Write_Address), 64'(32'd0));

        // xfer_done while idle does nothing
        xfer_done = 1'b1; OUT_DATA = 32'hDEAD_BEEF; PSLVERR = 1'b1;
        tick();
        xfer_done = 1'b0; PSLVERR = 1'b0;
        chk("idle_done", 64'(done), 64'(2'b00));
        chk("idle_trans", 64'(Trans), 64'(1'b0));

        // Port 0 write
        rw = 2'b00; addr0 = 32'd12; wdata0 = 32'd11; strb0 = 4'hF;
        do_txn(2'b01, 3, 1'b0, 32'h5555_0000);

        // Port 1 read
        rw = 2'b10; addr1 = 32'd12;
        do_txn(2'b10, 3, 1'b0, 32'd11);

        // Contention right after reset: CPU, then DMA, then CPU again
        PRESET = 1'b1; tick(); PRESET = 1'b0; last_w = 1;
        rw = 2'b01; addr0 = 32'h100; addr1 = 32'h200; wdata1 = 32'h77; strb1 = 4'h3;
        do_txn(2'b11, 2, 1'b0, 32'hA5A5_A5A5);
        rw = 2'b01; addr1 = 32'h204;
        do_txn(2'b10, 1, 1'b0, 32'h0);
        rw = 2'b10; addr0 = 32'h108; wdata0 = 32'h9; strb0 = 4'h1; addr1 = 32'h208;
        do_txn(2'b11, 4, 1'b0, 32'h1234_5678);

        // Timeout on a write
        rw = 2'b00; addr0 = 32'h40; wdata0 = 32'h99; strb0 = 4'hC;
        do_txn(2'b01, 0, 1'b0, 32'h0);

        // Slave error on a read
        rw = 2'b10; addr1 = 32'h44;
        do_txn(2'b10, 5, 1'b1, 32'hCAFE_0001);

        // Completion on the last allowed cycle reports PSLVERR, not timeout
        rw = 2'b01; addr0 = 32'h48;
        do_txn(2'b01, TIMEOUT, 1'b0, 32'h0BAD_F00D);
        do_txn(2'b01, TIMEOUT, 1'b1, 32'h0000_0042);

        // Reset in the middle of a CPU transfer (last grant is CPU here)
        rw = 2'b00; addr0 = 32'h80; wdata0 = 32'h1; strb0 = 4'hF;
        req = 2'b01;
        tick();
        chk("mid_gnt", 64'(gnt), 64'(2'b01));
        tick();
        tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0; req = 2'b00;
        chk("mid_trans", 64'(Trans), 64'(1'b0));
        chk("mid_gntclr", 64'(gnt), 64'(2'b00));
        chk("mid_done", 64'(done), 64'(2'b00));
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mid_no_done", 64'(done), 64'(2'b00));
            tick();
        end
        last_w = 1;
        rw = 2'b00; addr0 = 32'h84; addr1 = 32'h88;
        do_txn(2'b11, 2, 1'b0, 32'h0);
        do_txn(2'b10, 2, 1'b0, 32'h0);

        // Random transactions
        for (int t = 0; t < 40; t++) begin
            rw     = 2'($urandom);
            addr0  = $urandom; addr1  = $urandom;
            wdata0 = $urandom; wdata1 = $urandom;
            strb0  = 4'($urandom); strb1 = 4'($urandom);
            rq     = 2'($urandom_range(1, 3));
            lat    = int'($urandom_range(1, TIMEOUT + 2));
            se     = 1'($urandom);
            od     = $urandom;
            do_txn(rq, lat, se, od);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
